// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_e;

  localparam int unsigned DATA_BITS_DEF = 8;

  // Requester index width; a single requester still gets a 1-bit index
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first pending request at or after ptr,
// wrapping from the highest index back to 0.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               gnt_valid_c,
  output logic [IDW-1:0]     gnt_idx_c
);

  int unsigned cand;

  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!gnt_valid_c && (i == cand) && req[i]) begin
          gnt_valid_c = 1'b1;
          gnt_idx_c   = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte sources.
// Define UART_TX_ARB_LOCK_EN to add ReqLock (back-to-back bytes from one owner).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned DATA_BITS = DATA_BITS_DEF,
  localparam int unsigned IDW       = id_width(NUM_REQ)
) (
  input  logic                          Clock,
  input  logic                          ResetN,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [NUM_REQ*DATA_BITS-1:0]  ReqData,
  output logic [NUM_REQ-1:0]            ReqAck,
  output logic                          TxStart,
  output logic [DATA_BITS-1:0]          DataOut,
  input  logic                          TxReady,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            ReqLock,
`endif
  output logic [IDW-1:0]                GrantId,
  output logic                          Busy
);

  state_e                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;

  logic                   gnt_valid_c;
  logic [IDW-1:0]         gnt_idx_c;
  logic [IDW-1:0]         sel_idx_c;
  logic [DATA_BITS-1:0]   sel_byte_c;
  logic                   lock_hit_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (ReqValid),
    .ptr         (ptr_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  // Byte source: the new winner from IDLE, the current owner when locked in BUSY
  always_comb begin
    sel_idx_c  = (state_q == BUSY) ? grant_q : gnt_idx_c;
    sel_byte_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == sel_idx_c) sel_byte_c = ReqData[i*DATA_BITS +: DATA_BITS];
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  always_comb begin
    lock_hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((IDW'(i) == grant_q) && ReqLock[i] && ReqValid[i]) lock_hit_c = 1'b1;
    end
  end
`else
  assign lock_hit_c = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    start_d = 1'b0;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          state_d = ISSUE;
          grant_d = gnt_idx_c;
          data_d  = sel_byte_c;
          ptr_d   = (gnt_idx_c == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
        end
      end
      ISSUE: state_d = BUSY;
      BUSY: begin
        if (TxReady) begin
          if (lock_hit_c) begin
            state_d = ISSUE;
            data_d  = sel_byte_c;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ack_d[i] = (state_d == ISSUE) && (IDW'(i) == grant_d);
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign ReqAck  = ack_q;
  assign TxStart = start_q;
  assign DataOut = data_q;
  assign GrantId = grant_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester and transmitter models drive the
// DUT, a monitor pops the expected (id, byte) on every TxStart and checks it.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DB = 8;

  logic             Clock;
  logic             ResetN;
  logic [NR-1:0]    ReqValid;
  logic [NR*DB-1:0] ReqData;
  logic [NR-1:0]    ReqAck;
  logic             TxStart;
  logic [DB-1:0]    DataOut;
  logic             TxReady;
  logic [1:0]       GrantId;
  logic             Busy;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NR-1:0]    ReqLock;
`endif

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .DATA_BITS (DB)
  ) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .ReqValid (ReqValid),
    .ReqData  (ReqData),
    .ReqAck   (ReqAck),
    .TxStart  (TxStart),
    .DataOut  (DataOut),
    .TxReady  (TxReady),
`ifdef UART_TX_ARB_LOCK_EN
    .ReqLock  (ReqLock),
`endif
    .GrantId  (GrantId),
    .Busy     (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int          errors = 0;
  int          checks = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_e;
  logic [7:0]  src_mem [NR][16];
  int          src_wr  [NR];
  int          src_rd  [NR];
  int          tx_delay   = 3;
  int          force_req  = 0;
  int          force_done = 0;
  int          tx_cnt;
  logic [7:0]  held;
  bit          in_tx = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_src(input int i, input logic [7:0] b);
    src_mem[i][src_wr[i]] = b;
    src_wr[i]++;
  endtask

  task automatic exp_push(input int id, input logic [7:0] b);
    exp_q.push_back({4'(id), b});
  endtask

  // Requester model: present next queued byte, advance on ReqAck
  initial begin
    for (int i = 0; i < NR; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    ReqValid = '0;
    ReqData  = '0;
    forever begin
      @(negedge Clock);
      for (int i = 0; i < NR; i++) if (ReqAck[i]) src_rd[i]++;
      for (int i = 0; i < NR; i++) begin
        if (src_rd[i] < src_wr[i]) begin
          ReqValid[i]       = 1'b1;
          ReqData[i*DB +: DB] = src_mem[i][src_rd[i]];
        end else begin
          ReqValid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: TxReady pulse tx_delay cycles after TxStart, or on demand
  initial begin
    TxReady = 1'b0;
    tx_cnt  = 0;
    forever begin
      @(negedge Clock);
      TxReady = 1'b0;
      if (!ResetN) tx_cnt = 0;
      else if (force_done != force_req) begin
        force_done = force_req;
        TxReady    = 1'b1;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) TxReady = 1'b1;
      end else if (TxStart) tx_cnt = tx_delay;
    end
  end

  // Monitor: scoreboard compare on every TxStart, protocol checks otherwise
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (!ResetN) in_tx = 1'b0;
      else if (TxStart) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txstart: got id %0d data %0h expected no start", GrantId, DataOut);
        end else begin
          exp_e = exp_q.pop_front();
          check("grant_id",   32'(GrantId), 32'(exp_e[11:8]));
          check("data_out",   32'(DataOut), 32'(exp_e[7:0]));
          check("req_ack",    32'(ReqAck),  32'(1) << exp_e[11:8]);
          check("busy_issue", 32'(Busy),    32'(1));
          held  = exp_e[7:0];
          in_tx = 1'b1;
        end
      end else begin
        check("no_stray_ack", 32'(ReqAck), 32'(0));
        if (Busy && in_tx) check("data_hold", 32'(DataOut), 32'(held));
        if (!Busy) in_tx = 1'b0;
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_txstart"}, 32'(TxStart), 32'(0));
    check({tag, "_reqack"},  32'(ReqAck),  32'(0));
    check({tag, "_busy"},    32'(Busy),    32'(0));
    check({tag, "_grantid"}, 32'(GrantId), 32'(0));
    check({tag, "_dataout"}, 32'(DataOut), 32'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check_zero_outputs(tag);
    @(negedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || Busy) && n < 300) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_%s: got %0d grants outstanding expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic wait_ack(input int idx);
    int n = 0;
    while (!ReqAck[idx] && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_ack%0d: got no ReqAck expected one within 100 cycles", idx);
    end
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!(Busy && !TxStart) && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_busy: got Busy=%0b expected BUSY state within 100 cycles", Busy);
    end
  endtask

  initial begin
`ifdef UART_TX_ARB_LOCK_EN
    ReqLock = '0;
`endif
    ResetN = 1'b0;
    repeat (3) @(negedge Clock);
    check_zero_outputs("por");
    ResetN = 1'b1;
    @(negedge Clock);

    // Stray TxReady while idle with nothing pending
    force_req++;
    repeat (4) @(negedge Clock);
    check("idle_busy",  32'(Busy),    32'(0));
    check("idle_start", 32'(TxStart), 32'(0));

    // Single requester
    push_src(0, 8'hAA);
    exp_push(0, 8'hAA);
    drain("single");
    check("single_last_grant", 32'(GrantId), 32'(0));

    // All four continuously valid, two bytes each
    do_reset("rst_a");
    for (int i = 0; i < NR; i++) push_src(i, 8'h10 + 8'(i));
    for (int i = 0; i < NR; i++) push_src(i, 8'h20 + 8'(i));
    for (int i = 0; i < NR; i++) exp_push(i, 8'h10 + 8'(i));
    for (int i = 0; i < NR; i++) exp_push(i, 8'h20 + 8'(i));
    drain("rr4");

    // Pointer after granting 2 favours 3 over 1
    do_reset("rst_b");
    push_src(2, 8'h52);
    exp_push(2, 8'h52);
    wait_ack(2);
    push_src(1, 8'h51);
    push_src(3, 8'h53);
    exp_push(3, 8'h53);
    exp_push(1, 8'h51);
    drain("ptr");
    check("ptr_last_grant", 32'(GrantId), 32'(1));

    // Reset while BUSY drops the byte and restarts arbitration at 0
    tx_delay = 20;
    push_src(1, 8'h61);
    exp_push(1, 8'h61);
    wait_busy();
    do_reset("rst_busy");
    tx_delay = 3;
    repeat (3) @(negedge Clock);
    check("post_rst_idle", 32'(Busy), 32'(0));
    push_src(0, 8'h70);
    push_src(3, 8'h73);
    exp_push(0, 8'h70);
    exp_push(3, 8'h73);
    drain("post_rst");

`ifdef UART_TX_ARB_LOCK_EN
    // Locked owner keeps the transmitter until it runs dry
    ReqLock = 4'b0010;
    push_src(1, 8'h41);
    push_src(1, 8'h42);
    push_src(1, 8'h43);
    exp_push(1, 8'h41);
    wait_ack(1);
    push_src(0, 8'h30);
    exp_push(1, 8'h42);
    exp_push(1, 8'h43);
    exp_push(0, 8'h30);
    drain("lock");
    ReqLock = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
